// File: rtl/npc_ras_unit_pkg.sv
// Shared next-PC select encodings and target helpers for the fetch-stage PC unit.
package npc_ras_unit_pkg;

   localparam logic [1:0] NPC_SEL_SEQ = 2'd0;
   localparam logic [1:0] NPC_SEL_BR  = 2'd1;
   localparam logic [1:0] NPC_SEL_J   = 2'd2;
   localparam logic [1:0] NPC_SEL_JR  = 2'd3;

   localparam logic [4:0] RA_REG = 5'd31;

   // Branch offset is a word offset relative to the delay-slot address.
   function automatic logic [31:0] br_target(input logic [31:0] pc4, input logic [15:0] imm);
      return pc4 + {{14{imm[15]}}, imm, 2'b00};
   endfunction

   function automatic logic [31:0] j_target(input logic [3:0] pc4_hi, input logic [25:0] idx);
      return {pc4_hi, idx, 2'b00};
   endfunction

endpackage

// File: rtl/npc_ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry, and an
// empty pop is ignored. Push and pop together replace the top in place.
module npc_ras_stack #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] push_data_i,
   output logic [W-1:0] top_o,
   output logic         valid_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [W-1:0]    mem_q [DEPTH];
   logic [W-1:0]    mem_d [DEPTH];
   logic [PtrW-1:0] ptr_q, ptr_d, top_idx;
   logic [CntW-1:0] cnt_q, cnt_d;

   // ptr_q is the next free slot, so the top lives one below it (mod DEPTH).
   assign top_idx = ptr_q - PtrW'(1);
   assign valid_o = (cnt_q != '0);
   assign top_o   = valid_o ? mem_q[top_idx] : '0;

   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push_i && pop_i) begin
         if (cnt_q == '0) begin
            mem_d[ptr_q] = push_data_i;
            ptr_d        = ptr_q + PtrW'(1);
            cnt_d        = CntW'(1);
         end else begin
            mem_d[top_idx] = push_data_i;
         end
      end else if (push_i) begin
         mem_d[ptr_q] = push_data_i;
         ptr_d        = ptr_q + PtrW'(1);
         if (cnt_q != CntW'(DEPTH)) begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else if (pop_i && (cnt_q != '0)) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '{default: '0};
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/npc_ras_unit.sv
// Fetch PC register and next-PC select with one delay slot, plus a return-address
// stack and return-hit counters that observe (but never steer) register jumps.
module npc_ras_unit
   import npc_ras_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
   parameter int unsigned RAS_DEPTH = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_f,
   input  logic             d_valid,
   input  logic [1:0]       npc_sel_d,
   input  logic             cmp_taken_d,
   input  logic             link_d,
   input  logic [31:0]      instr_d,
   input  logic [31:0]      pc4_d,
   input  logic [31:0]      j_reg,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [31:0]      epc,
   input  logic             perf_clr,
   output logic [31:0]      pc_f,
   output logic [31:0]      pc4_f,
   output logic             pc_misalign,
   output logic [31:0]      ras_top,
   output logic             ras_valid,
   output logic             ras_hit,
   output logic [CNT_W-1:0] ret_cnt,
   output logic [CNT_W-1:0] ret_hit_cnt
);

   logic [31:0]      pc_q, pc_d;
   logic             ras_hit_q, ras_hit_d;
   logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
   logic [CNT_W-1:0] ret_hit_cnt_q, ret_hit_cnt_d;
   logic             accept, ret, push, hit_now;
   logic             unused_instr;

   assign unused_instr = ^{instr_d[31:26], instr_d[20:16]};

   assign accept  = d_valid & ~stall_f & ~exc_req & ~eret_req;
   assign ret     = accept & (npc_sel_d == NPC_SEL_JR) & (instr_d[25:21] == RA_REG) & ~link_d;
   assign push    = accept & link_d & (npc_sel_d != NPC_SEL_SEQ);
   assign hit_now = ret & ras_valid & (ras_top == j_reg);

   npc_ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (32)
   ) u_stack (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .push_i      (push),
      .pop_i       (ret),
      .push_data_i (pc4_d + 32'd4),
      .top_o       (ras_top),
      .valid_o     (ras_valid)
   );

   always_comb begin
      pc_d = pc_q + 32'd4;
      if (exc_req) begin
         pc_d = EXC_VEC;
      end else if (eret_req) begin
         pc_d = epc;
      end else if (stall_f) begin
         pc_d = pc_q;
      end else if (d_valid) begin
         case (npc_sel_d)
            NPC_SEL_BR: if (cmp_taken_d) pc_d = br_target(pc4_d, instr_d[15:0]);
            NPC_SEL_J:  pc_d = j_target(pc4_d[31:28], instr_d[25:0]);
            NPC_SEL_JR: pc_d = j_reg;
            default:    pc_d = pc_q + 32'd4;
         endcase
      end
   end

   // perf_clr beats any same-cycle increment; both counters stick at all-ones.
   always_comb begin
      ras_hit_d     = hit_now;
      ret_cnt_d     = ret_cnt_q;
      ret_hit_cnt_d = ret_hit_cnt_q;
      if (perf_clr) begin
         ret_cnt_d     = '0;
         ret_hit_cnt_d = '0;
      end else begin
         if (ret && (ret_cnt_q != '1)) begin
            ret_cnt_d = ret_cnt_q + CNT_W'(1);
         end
         if (hit_now && (ret_hit_cnt_q != '1)) begin
            ret_hit_cnt_d = ret_hit_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         ras_hit_q     <= 1'b0;
         ret_cnt_q     <= '0;
         ret_hit_cnt_q <= '0;
      end else begin
         pc_q          <= pc_d;
         ras_hit_q     <= ras_hit_d;
         ret_cnt_q     <= ret_cnt_d;
         ret_hit_cnt_q <= ret_hit_cnt_d;
      end
   end

   assign pc_f        = pc_q;
   assign pc4_f       = pc_q + 32'd4;
   assign pc_misalign = (pc_q[1:0] != 2'b00);
   assign ras_hit     = ras_hit_q;
   assign ret_cnt     = ret_cnt_q;
   assign ret_hit_cnt = ret_hit_cnt_q;

endmodule

// File: tb/tb_npc_ras_unit.sv
// Scoreboard bench for npc_ras_unit: directed scenarios then random traffic, each
// cycle's expected state queued by a list-based reference model and popped by a monitor.
module tb_npc_ras_unit;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CW     = 3;
   localparam int          SAT    = (1 << CW) - 1;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC    = 32'h0000_4180;
   localparam logic [31:0] JR_RA  = 32'h03E0_0008;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall_f, d_valid, cmp_taken_d, link_d, exc_req, eret_req, perf_clr;
   logic [1:0]    npc_sel_d;
   logic [31:0]   instr_d, pc4_d, j_reg, epc;
   logic [31:0]   pc_f, pc4_f, ras_top;
   logic          pc_misalign, ras_valid, ras_hit;
   logic [CW-1:0] ret_cnt, ret_hit_cnt;

   npc_ras_unit #(
      .RESET_PC  (RST_PC),
      .EXC_VEC   (EXC),
      .RAS_DEPTH (DEPTH),
      .CNT_W     (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_f     (stall_f),
      .d_valid     (d_valid),
      .npc_sel_d   (npc_sel_d),
      .cmp_taken_d (cmp_taken_d),
      .link_d      (link_d),
      .instr_d     (instr_d),
      .pc4_d       (pc4_d),
      .j_reg       (j_reg),
      .exc_req     (exc_req),
      .eret_req    (eret_req),
      .epc         (epc),
      .perf_clr    (perf_clr),
      .pc_f        (pc_f),
      .pc4_f       (pc4_f),
      .pc_misalign (pc_misalign),
      .ras_top     (ras_top),
      .ras_valid   (ras_valid),
      .ras_hit     (ras_hit),
      .ret_cnt     (ret_cnt),
      .ret_hit_cnt (ret_hit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] top;
      logic        valid;
      logic        hit;
      int          rc;
      int          hc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   logic        m_hit;
   int          m_rc, m_hc;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC;
      m_ras.delete();
      m_hit = 1'b0;
      m_rc = 0;
      m_hc = 0;
   endtask

   // Reference: returns are a bounded list of return addresses, newest at the back.
   task automatic step();
      logic        acc, r, p;
      int          off;
      logic [31:0] npc;
      exp_t        e;
      acc = d_valid && !stall_f && !exc_req && !eret_req;
      r   = acc && npc_sel_d == 2'd3 && instr_d[25:21] == 5'd31 && !link_d;
      p   = acc && link_d && npc_sel_d != 2'd0;
      if (exc_req) npc = EXC;
      else if (eret_req) npc = epc;
      else if (stall_f) npc = m_pc;
      else if (d_valid && npc_sel_d == 2'd1 && cmp_taken_d) begin
         off = $signed(instr_d[15:0]);
         npc = pc4_d + 32'(off * 4);
      end
      else if (d_valid && npc_sel_d == 2'd2)
         npc = (pc4_d & 32'hF000_0000) | (32'(instr_d[25:0]) * 4);
      else if (d_valid && npc_sel_d == 2'd3) npc = j_reg;
      else npc = m_pc + 32'd4;
      m_pc  = npc;
      m_hit = r && m_ras.size() > 0 && m_ras[$] == j_reg;
      if (perf_clr) begin
         m_rc = 0;
         m_hc = 0;
      end else begin
         if (r && m_rc < SAT) m_rc++;
         if (m_hit && m_hc < SAT) m_hc++;
      end
      if (r && m_ras.size() > 0) void'(m_ras.pop_back());
      if (p) begin
         m_ras.push_back(pc4_d + 32'd4);
         if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      e.pc    = m_pc;
      e.valid = m_ras.size() > 0;
      e.top   = e.valid ? m_ras[$] : 32'd0;
      e.hit   = m_hit;
      e.rc    = m_rc;
      e.hc    = m_hc;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_f", pc_f, e.pc);
            chk("pc4_f", pc4_f, e.pc + 32'd4);
            chk("pc_misalign", 32'(pc_misalign), 32'(e.pc[1:0] != 2'b00));
            chk("ras_valid", 32'(ras_valid), 32'(e.valid));
            chk("ras_top", ras_top, e.top);
            chk("ras_hit", 32'(ras_hit), 32'(e.hit));
            chk("ret_cnt", 32'(ret_cnt), 32'(e.rc));
            chk("ret_hit_cnt", 32'(ret_hit_cnt), 32'(e.hc));
         end
      end
   end

   // Each driver task starts just after a falling edge and returns at the next one.
   task automatic idle_in();
      stall_f = 0; d_valid = 0; npc_sel_d = 2'd0; cmp_taken_d = 0; link_d = 0;
      instr_d = 32'd0; pc4_d = 32'd0; j_reg = 32'd0; exc_req = 0; eret_req = 0;
      epc = 32'd0; perf_clr = 0;
   endtask

   task automatic finish_cyc();
      step();
      @(negedge clk);
   endtask

   task automatic cyc_idle(input logic clr);
      idle_in(); perf_clr = clr; finish_cyc();
   endtask

   task automatic cyc_br(input logic [31:0] p4, input logic [15:0] imm, input logic tk);
      idle_in(); d_valid = 1; npc_sel_d = 2'd1; pc4_d = p4; instr_d = {16'h1000, imm};
      cmp_taken_d = tk; finish_cyc();
   endtask

   task automatic cyc_jal(input logic [31:0] p4);
      idle_in(); d_valid = 1; npc_sel_d = 2'd2; link_d = 1; pc4_d = p4;
      instr_d = 32'h0C00_0C40; finish_cyc();
   endtask

   task automatic cyc_jr(input logic [31:0] jr, input logic clr);
      idle_in(); d_valid = 1; npc_sel_d = 2'd3; instr_d = JR_RA; j_reg = jr;
      pc4_d = 32'h0000_3200; perf_clr = clr; finish_cyc();
   endtask

   task automatic cyc_rand();
      idle_in();
      d_valid     = $urandom_range(0, 3) != 0;
      npc_sel_d   = 2'($urandom_range(0, 3));
      cmp_taken_d = 1'($urandom_range(0, 1));
      link_d      = $urandom_range(0, 2) == 0;
      instr_d     = $urandom;
      if ($urandom_range(0, 1) == 1) instr_d[25:21] = 5'd31;
      pc4_d       = $urandom & 32'hFFFF_FFFC;
      j_reg       = (m_ras.size() > 0 && $urandom_range(0, 1) == 1) ? m_ras[$] : $urandom;
      stall_f     = $urandom_range(0, 7) == 0;
      exc_req     = $urandom_range(0, 31) == 0;
      eret_req    = $urandom_range(0, 31) == 0;
      epc         = $urandom;
      perf_clr    = $urandom_range(0, 63) == 0;
      finish_cyc();
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : main
      idle_in();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_pc", pc_f, RST_PC);
      chk("reset_ras_valid", 32'(ras_valid), 32'd0);
      chk("reset_ret_cnt", 32'(ret_cnt), 32'd0);
      chk("reset_ras_hit", 32'(ras_hit), 32'd0);

      repeat (3) cyc_idle(1'b0);
      chk("free_run_pc", pc_f, 32'h0000_300C);

      cyc_br(32'h0000_3010, 16'hFFFC, 1'b1);
      chk("br_taken", pc_f, 32'h0000_3000);
      cyc_br(32'h0000_3010, 16'hFFFC, 1'b0);
      chk("br_not_taken", pc_f, 32'h0000_3004);

      idle_in(); stall_f = 1; d_valid = 1; npc_sel_d = 2'd2; instr_d = 32'h0800_0100;
      pc4_d = 32'h0000_3010; finish_cyc();
      chk("stall_hold", pc_f, 32'h0000_3004);
      idle_in(); stall_f = 1; exc_req = 1; d_valid = 1; npc_sel_d = 2'd2; finish_cyc();
      chk("exc_over_stall", pc_f, EXC);
      idle_in(); eret_req = 1; epc = 32'h0000_3020; finish_cyc();
      chk("eret", pc_f, 32'h0000_3020);
      idle_in(); exc_req = 1; eret_req = 1; epc = 32'h0000_3040; finish_cyc();
      chk("exc_beats_eret", pc_f, EXC);

      cyc_jal(32'h0000_3004);
      cyc_jal(32'h0000_3104);
      chk("nest_top", ras_top, 32'h0000_3108);
      cyc_jr(32'h0000_3108, 1'b0);
      chk("nest_hit1", 32'(ras_hit), 32'd1);
      cyc_jr(32'h0000_3008, 1'b0);
      chk("nest_hit2", 32'(ras_hit), 32'd1);
      chk("nest_ret_cnt", 32'(ret_cnt), 32'd2);
      chk("nest_hit_cnt", 32'(ret_hit_cnt), 32'd2);

      cyc_idle(1'b1);
      for (int i = 0; i < 5; i++) cyc_jal(32'h0000_5000 + 32'(i) * 32'h100);
      for (int i = 4; i >= 0; i--) begin
         cyc_jr(32'h0000_5004 + 32'(i) * 32'h100, 1'b0);
         chk("ovf_hit", 32'(ras_hit), 32'(i > 0));
      end
      chk("ovf_hit_cnt", 32'(ret_hit_cnt), 32'd4);
      chk("ovf_ret_cnt", 32'(ret_cnt), 32'd5);
      chk("ovf_empty", 32'(ras_valid), 32'd0);

      cyc_idle(1'b1);
      repeat (9) cyc_jr(32'h0000_1234, 1'b0);
      chk("sat_ret_cnt", 32'(ret_cnt), 32'(SAT));
      cyc_jr(32'h0000_1234, 1'b1);
      chk("clr_over_inc", 32'(ret_cnt), 32'd0);

      cyc_jal(32'h0000_6000);
      idle_in(); stall_f = 1; d_valid = 1; npc_sel_d = 2'd2; finish_cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pc", pc_f, RST_PC);
      chk("async_rst_ras", 32'(ras_valid), 32'd0);
      chk("async_rst_top", ras_top, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      repeat (1500) cyc_rand();
      cyc_idle(1'b0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
